tamagotchi_vitals: RTL

- Pet-state engine behind the tamagotchi top-level; produces the 8-bit status byte driven onto uo_out.
- Consumes debounced, single-cycle button pulses from the input conditioner.
- Divides clk into game ticks, ages three saturating vital counters (hunger, happy, energy) and runs the pet lifecycle FSM.

---
 rtl/tamagotchi_vitals.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tamagotchi_vitals.sv
// Pet-state engine: game-tick prescaler, three saturating vitals (hunger, happy,
// energy) and the pet lifecycle FSM. The 8-bit status byte is
// {state, alert, happy}.
// Optional build macro TAMA_REVIVE_EN: pressing feed and play together while
// DEAD revives the pet.
module tamagotchi_vitals #(
  parameter int unsigned TICK_DIV     = 1000000,
  parameter int unsigned ACTION_TICKS = 4,
  parameter int unsigned SICK_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_feed,
  input  logic       btn_play,
  input  logic       btn_sleep,
  output logic [7:0] status,
  output logic [3:0] hunger,
  output logic [3:0] happy,
  output logic [3:0] energy,
  output logic [2:0] state,
  output logic       tick
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ActW = $clog2(ACTION_TICKS + 1);
  localparam int unsigned NegW = $clog2(SICK_LIMIT + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StEating   = 3'd1,
    StPlaying  = 3'd2,
    StSleeping = 3'd3,
    StSick     = 3'd4,
    StDead     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        hunger_q, hunger_d;
  logic [3:0]        happy_q, happy_d;
  logic [3:0]        energy_q, energy_d;
  logic [ActW-1:0]   act_q, act_d;
  logic [NegW-1:0]   neg_q, neg_d;
  logic [7:0]        status_q, status_d;
  logic              alert_d;

  function automatic logic [3:0] sat_add(input logic [3:0] v, input logic [1:0] d);
    logic [4:0] s;
    s = {1'b0, v} + {3'b000, d};
    return (s > 5'd15) ? 4'hf : s[3:0];
  endfunction

  function automatic logic [3:0] sat_sub(input logic [3:0] v, input logic [1:0] d);
    return (v < {2'b00, d}) ? 4'h0 : (v - {2'b00, d});
  endfunction

  // Tick is a decode of the prescaler register, gated by enable.
  assign tick = ena && (cnt_q == CntW'(TICK_DIV - 1));

  // Next-state: prescaler, per-state vital rules and FSM transitions.
  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    hunger_d = hunger_q;
    happy_d  = happy_q;
    energy_d = energy_q;
    act_d    = act_q;
    neg_d    = neg_q;
    if (ena) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            hunger_d = sat_add(hunger_q, 2'd1);
            happy_d  = sat_sub(happy_q, 2'd1);
            energy_d = sat_sub(energy_q, 2'd1);
            if (hunger_d == 4'hf) begin
              state_d = StSick;
              neg_d   = '0;
            end
          end
          // Commands override a simultaneous starvation transition.
          if (btn_feed) begin
            state_d = StEating;
            act_d   = ActW'(ACTION_TICKS);
          end else if (btn_play && (energy_q != 4'h0)) begin
            state_d = StPlaying;
          end else if (btn_sleep) begin
            state_d = StSleeping;
          end
        end
        StEating: begin
          if (tick) begin
            hunger_d = sat_sub(hunger_q, 2'd3);
            act_d    = (act_q == '0) ? '0 : act_q - ActW'(1);
            if (act_d == '0) state_d = StIdle;
          end
        end
        StPlaying: begin
          if (tick) begin
            happy_d  = sat_add(happy_q, 2'd2);
            energy_d = sat_sub(energy_q, 2'd1);
            hunger_d = sat_add(hunger_q, 2'd1);
            if (energy_d == 4'h0) state_d = StIdle;
          end
          if (btn_play) state_d = StIdle;
        end
        StSleeping: begin
          if (tick) begin
            energy_d = sat_add(energy_q, 2'd2);
            hunger_d = sat_add(hunger_q, 2'd1);
            if (energy_d == 4'hf) state_d = StIdle;
          end
          if (btn_sleep) state_d = StIdle;
        end
        StSick: begin
          if (tick) begin
            happy_d = sat_sub(happy_q, 2'd1);
            neg_d   = neg_q + NegW'(1);
            if (neg_d == NegW'(SICK_LIMIT)) state_d = StDead;
          end
          if (btn_feed) begin
            state_d = StEating;
            act_d   = ActW'(ACTION_TICKS);
            neg_d   = '0;
          end
        end
        StDead: begin
`ifdef TAMA_REVIVE_EN
          if (btn_feed && btn_play) begin
            state_d  = StIdle;
            hunger_d = 4'h0;
            happy_d  = 4'h8;
            energy_d = 4'h8;
            act_d    = '0;
            neg_d    = '0;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
    alert_d  = (hunger_d >= 4'd12) || (happy_d <= 4'd3) || (energy_d <= 4'd3) ||
               (state_d == StSick) || (state_d == StDead);
    status_d = {state_d, alert_d, happy_d};
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hunger_q <= 4'h0;
      happy_q  <= 4'hf;
      energy_q <= 4'hf;
      act_q    <= '0;
      neg_q    <= '0;
      status_q <= 8'h0f;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hunger_q <= hunger_d;
      happy_q  <= happy_d;
      energy_q <= energy_d;
      act_q    <= act_d;
      neg_q    <= neg_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;
  assign hunger = hunger_q;
  assign happy  = happy_q;
  assign energy = energy_q;
  assign state  = state_q;

endmodule
